// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_fetch_pkg;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // presenting a fetch request
    S_WAIT = 2'd1,  // request accepted, waiting for the word
    S_HOLD = 2'd2,  // word buffered, offered downstream
    S_ERR  = 2'd3   // stopped on error until redirected
  } state_t;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch: one outstanding word fetch, single-entry buffer to
// decode/execute, PC redirect with wrong-path squash, error/timeout detect.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
  parameter int              TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_err
);

  state_t          state, state_nx;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nx;
  logic [XLEN-1:0] inst_q, inst_nx;
  logic [XLEN-1:0] pc_q, pc_nx;
  logic            drop, drop_nx;
  logic [7:0]      tmo_cnt, tmo_nx;

  logic            hs;
  logic            tmo_hit;
  logic [XLEN-1:0] tgt;
  logic            tgt_mis;

  assign hs       = (state == S_REQ) && imem_req_ready;
  assign tmo_hit  = (tmo_cnt == 8'(TIMEOUT - 1));
  assign tgt      = {redirect_pc[XLEN-1:2], 2'b00};
  assign tgt_mis  = |redirect_pc[1:0];

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = fetch_pc;
  assign inst_valid     = (state == S_HOLD);
  assign fetch_err      = (state == S_ERR);
  assign inst           = inst_q;
  assign pc             = pc_q;

  // Next-state: redirect overrides normal sequencing; drop is cleared on
  // entering S_ERR so a stale squash never eats the first post-error fetch.
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    inst_nx     = inst_q;
    pc_nx       = pc_q;
    drop_nx     = drop;
    tmo_nx      = tmo_cnt;
    if (state == S_WAIT) tmo_nx = tmo_cnt + 8'd1;
    if (redirect_valid) begin
      fetch_pc_nx = tgt;
      if (tgt_mis) begin
        state_nx = S_ERR;
        drop_nx  = 1'b0;
      end else begin
        case (state)
          S_REQ: if (hs) begin
            state_nx = S_WAIT;
            drop_nx  = 1'b1;
            tmo_nx   = 8'd0;
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              state_nx = S_REQ;
              drop_nx  = 1'b0;
            end else if (tmo_hit) begin
              state_nx = S_ERR;
              drop_nx  = 1'b0;
            end else begin
              drop_nx  = 1'b1;
            end
          end
          default: state_nx = S_REQ;  // S_HOLD (consumed or flushed), S_ERR
        endcase
      end
    end else begin
      case (state)
        S_REQ: if (hs) begin
          state_nx = S_WAIT;
          tmo_nx   = 8'd0;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop) begin
              state_nx = S_REQ;
              drop_nx  = 1'b0;
            end else if (imem_rsp_err) begin
              state_nx = S_ERR;
            end else begin
              inst_nx  = imem_rsp_data;
              pc_nx    = fetch_pc;
              state_nx = S_HOLD;
            end
          end else if (tmo_hit) begin
            state_nx = S_ERR;
            drop_nx  = 1'b0;
          end
        end
        S_HOLD: if (inst_ready) begin
          fetch_pc_nx = fetch_pc + XLEN'(INST_BYTES);
          state_nx    = S_REQ;
        end
        default: ;  // S_ERR holds until redirect
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      inst_q   <= '0;
      pc_q     <= '0;
      drop     <= 1'b0;
      tmo_cnt  <= 8'd0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      inst_q   <= inst_nx;
      pc_q     <= pc_nx;
      drop     <= drop_nx;
      tmo_cnt  <= tmo_nx;
    end
  end

endmodule
